// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath blocks: FSM state encoding and
// the default parallel word width.
package serial_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage : serial_pkg

// File: rtl/piso_serializer_if.sv
// Bundle of the serializer's word handshake and serial output signals, for
// blocks and benches that connect to piso_serializer as a group.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             ser_data;
    logic             ser_vld;
    logic             word_done;
    logic             busy;

    // Word producer side: offers words, observes the serial stream.
    modport master (
        output data,
        output valid,
        input  ready,
        input  ser_data,
        input  ser_vld,
        input  word_done,
        input  busy
    );

    // Serializer side: accepts words, drives the serial stream.
    modport slave (
        input  data,
        input  valid,
        output ready,
        output ser_data,
        output ser_vld,
        output word_done,
        output busy
    );
endinterface : piso_serializer_if

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word pending buffer so that
// consecutive words stream with no idle cycle between them.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = SERIAL_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             data_vld_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;
    logic             accept;

    // Move the shift register one position toward its output end.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end
        return {1'b0, v[WIDTH-1:1]};
    endfunction

    // Bit sitting at the output end of the shift register.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Ready only depends on the pending buffer, never on valid_i.
    assign ready_o = ~pend_vld_q;
    assign accept  = valid_i & ~pend_vld_q;
    assign busy_o  = (state_q == S_SHIFT) | pend_vld_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = data_i;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST_IDX) begin
                    // Last bit goes out now; chain the next word straight in.
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        shreg_d    = pend_q;
                        pend_vld_d = 1'b0;
                    end else if (accept) begin
                        shreg_d = data_i;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    shreg_d = shift_one(shreg_q);
                    cnt_d   = cnt_q + CW'(1);
                    if (accept) begin
                        pend_d     = data_i;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register in step
        // with the bit the shift register will present.
        vld_d  = (state_d == S_SHIFT);
        data_d = vld_d ? head_bit(shreg_d) : 1'b0;
        done_d = vld_d && (cnt_d == LAST_IDX);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            data_q     <= 1'b0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
        end
    end

    assign data_o      = data_q;
    assign data_vld_o  = vld_q;
    assign word_done_o = done_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) driven with the
// same word stream and checked bit by bit against hand-derived sequences.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    int         vectors     = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) bus_m ();
    piso_serializer_if #(.WIDTH(8)) bus_l ();

    assign bus_m.data  = data_in;
    assign bus_m.valid = valid_in;
    assign bus_l.data  = data_in;
    assign bus_l.valid = valid_in;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (bus_m.data),
        .valid_i     (bus_m.valid),
        .ready_o     (bus_m.ready),
        .data_o      (bus_m.ser_data),
        .data_vld_o  (bus_m.ser_vld),
        .word_done_o (bus_m.word_done),
        .busy_o      (bus_m.busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (bus_l.data),
        .valid_i     (bus_l.valid),
        .ready_o     (bus_l.ready),
        .data_o      (bus_l.ser_data),
        .data_vld_o  (bus_l.ser_vld),
        .word_done_o (bus_l.word_done),
        .busy_o      (bus_l.busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bit index i of word w on both serializers (MSB-first shows w[7-i]).
    task automatic check_bit(input logic [7:0] w, input int i);
        chk("data_msb", {31'd0, bus_m.ser_data}, {31'd0, w[7-i]});
        chk("data_lsb", {31'd0, bus_l.ser_data}, {31'd0, w[i]});
        chk("vld_msb",  {31'd0, bus_m.ser_vld}, 32'd1);
        chk("vld_lsb",  {31'd0, bus_l.ser_vld}, 32'd1);
        chk("done_msb", {31'd0, bus_m.word_done}, (i == 7) ? 32'd1 : 32'd0);
        chk("done_lsb", {31'd0, bus_l.word_done}, (i == 7) ? 32'd1 : 32'd0);
        $display("word %02h bit %0d: msb=%b lsb=%b done=%b/%b", w, i,
                 bus_m.ser_data, bus_l.ser_data, bus_m.word_done, bus_l.word_done);
    endtask

    task automatic check_ready(input logic exp);
        chk("ready_msb", {31'd0, bus_m.ready}, {31'd0, exp});
        chk("ready_lsb", {31'd0, bus_l.ready}, {31'd0, exp});
    endtask

    // Fully idle / reset output state on both serializers.
    task automatic check_idle(input string tag);
        chk({tag, "_data"}, {30'd0, bus_m.ser_data, bus_l.ser_data}, 32'd0);
        chk({tag, "_vld"},  {30'd0, bus_m.ser_vld, bus_l.ser_vld}, 32'd0);
        chk({tag, "_done"}, {30'd0, bus_m.word_done, bus_l.word_done}, 32'd0);
        chk({tag, "_busy"}, {30'd0, bus_m.busy, bus_l.busy}, 32'd0);
        check_ready(1'b1);
        $display("%s: idle state checked", tag);
    endtask

    // Single word from idle: accept, then 8 bits, then idle.
    task automatic single_word(input logic [7:0] w);
        valid_in = 1'b1;
        data_in  = w;
        check_ready(1'b1);
        tick();
        valid_in = 1'b0;
        check_bit(w, 0);
        chk("busy_shift", {30'd0, bus_m.busy, bus_l.busy}, 32'd3);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_bit(w, i);
        end
        tick();
        check_idle("after_word");
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset values
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Single words in both bit orders
        single_word(8'hA5);
        single_word(8'h05);

        // Back-to-back A5 then 3C: 16 contiguous bits
        valid_in = 1'b1;
        data_in  = 8'hA5;
        tick();
        data_in = 8'h3C;
        check_bit(8'hA5, 0);
        tick();
        valid_in = 1'b0;
        check_ready(1'b0);
        check_bit(8'hA5, 1);
        for (int i = 2; i < 8; i++) begin
            tick();
            check_bit(8'hA5, i);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check_bit(8'h3C, i);
        end
        tick();
        check_idle("after_stream");

        // Three words: C3 shifting, 5A pending, 96 held off until 5A moves
        valid_in = 1'b1;
        data_in  = 8'hC3;
        tick();
        data_in = 8'h5A;
        check_bit(8'hC3, 0);
        tick();
        data_in = 8'h96;
        check_ready(1'b0);
        check_bit(8'hC3, 1);
        for (int i = 2; i < 8; i++) begin
            tick();
            check_ready(1'b0);
            check_bit(8'hC3, i);
        end
        tick();
        check_ready(1'b1);
        check_bit(8'h5A, 0);
        tick();
        valid_in = 1'b0;
        check_ready(1'b0);
        check_bit(8'h5A, 1);
        for (int i = 2; i < 8; i++) begin
            tick();
            check_bit(8'h5A, i);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check_bit(8'h96, i);
        end
        tick();
        check_idle("after_three");

        // Reset on bit 4 of FF with 81 pending
        valid_in = 1'b1;
        data_in  = 8'hFF;
        tick();
        data_in = 8'h81;
        check_bit(8'hFF, 0);
        tick();
        valid_in = 1'b0;
        check_bit(8'hFF, 1);
        tick();
        check_bit(8'hFF, 2);
        tick();
        check_bit(8'hFF, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid_reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("after_abort");
        end
        single_word(8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_piso_serializer

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (legal values 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_i  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port valid_i  input  1  data_i is valid this cycle.
REQ-007 SHALL have port ready_o  output  1  block can accept a word this cycle.
REQ-008 SHALL have port data_o  output  1  serial bit stream, suitable for a downstream serial sequence detector.
REQ-009 SHALL have port data_vld_o  output  1  data_o carries a payload bit this cycle.
REQ-010 SHALL have port word_done_o  output  1  one-cycle pulse coincident with the last bit of each word.
REQ-011 SHALL have port busy_o  output  1  high while in S_SHIFT or while the pending buffer is occupied.

Function
REQ-012 SHALL transfer a word only on a cycle where valid_i and ready_o are both high ("accept").
REQ-013 SHALL drive ready_o = NOT pend_vld, where pend_vld marks a one-word pending buffer; ready_o SHALL NOT depend combinationally on valid_i.
REQ-014 SHALL implement states S_IDLE and S_SHIFT, with a shift register, a bit counter of width $clog2(WIDTH), and the pending buffer.
REQ-015 S_IDLE: on accept, SHALL load data_i into the shift register, clear the counter, and enter S_SHIFT; the first bit appears on data_o in the next cycle (latency 1).
REQ-016 S_SHIFT: each cycle, SHALL present one bit on data_o with data_vld_o=1, shift by one position toward the output end, and increment the counter.
REQ-017 S_SHIFT, not on the last bit: an accept SHALL write data_i into the pending buffer and set pend_vld.
REQ-018 On the last bit (counter = WIDTH-1), SHALL pulse word_done_o, then take the first applicable of:
  - pend_vld=1: load the pending word into the shift register, clear pend_vld, stay in S_SHIFT;
  - accept this cycle: load data_i directly into the shift register, stay in S_SHIFT;
  - otherwise: go to S_IDLE.
REQ-019 Back-to-back words SHALL stream with no idle cycle between the last bit of one word and the first bit of the next.
REQ-020 With pend_vld=1, ready_o SHALL be low; valid_i SHALL be ignored and no data is lost or overwritten.
REQ-021 In S_IDLE, SHALL drive data_o=0, data_vld_o=0 and word_done_o=0.
REQ-022 data_o, data_vld_o and word_done_o SHALL be registered outputs.

Reset
REQ-023 While rst_i=1 at a clock edge, SHALL return to S_IDLE and clear the counter, shift register, pending buffer and pend_vld.
REQ-024 Output values under reset SHALL be: data_o=0, data_vld_o=0, word_done_o=0, busy_o=0, ready_o=1 (ready_o from the cycle after reset).
REQ-025 A reset asserted mid-word SHALL abort the word and discard any pending word; no word_done_o pulse is issued for it.

Structure
REQ-026 The fsm state typedef (S_IDLE, S_SHIFT) SHALL reside in a shared package, serial_pkg, together with the WIDTH default constant.
REQ-027 SHALL be a single module with no sub-modules; the shift/count datapath is small enough to inline.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1; accept 8'hA5 from S_IDLE -> data_o = 1,0,1,0,0,1,0,1 on the 8 cycles starting 1 cycle after accept; word_done_o on the 8th bit; then S_IDLE.
REQ-029 MSB_FIRST=0; accept 8'hA5 -> data_o = 1,0,1,0,0,1,0,1 (bit 0 first); accept 8'h05 -> 1,0,1,0,0,0,0,0.
REQ-030 valid_i held high with 8'hA5 then 8'h3C -> 16 consecutive cycles with data_vld_o=1, no gap; word_done_o on cycles 8 and 16.
REQ-031 Third word offered while one word is shifting and one is pending -> ready_o=0 until the pending word moves to the shift register; all three words are serialized in order with no corruption.
REQ-032 rst_i asserted on bit 4 of 8'hFF with a pending 8'h81 -> outputs return to reset values next cycle; no further bits or word_done_o; a subsequent accept of 8'h81 serializes correctly.
